// File: rtl/sys_defs.sv
// Shared fetch-stage definitions.
// Queue depth and entry layout used by fetch_buffer and its storage.
package sys_defs;

  localparam int FQ_DEPTH   = 8;
  localparam int FQ_ENTRY_W = 96;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  function automatic logic [63:0] next_block(
    input logic [63:0] pc
  );
    return {pc[63:3] + 61'd1, 3'b000};
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch buffer ports: icache side, redirect and decode side.
// master is the buffer itself, slave is its environment.
interface fetch_buffer_if #(
  parameter int FQ_DEPTH = sys_defs::FQ_DEPTH
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [63:0]   Icache_data_out;
  logic          Icache_valid_out;
  logic          redirect_en;
  logic [63:0]   redirect_pc;
  logic [1:0]    deq_count;
  logic [63:0]   proc2Icache_addr;
  logic          stall_icache;
  logic [31:0]   inst0;
  logic [31:0]   inst1;
  logic [63:0]   pc0;
  logic [63:0]   pc1;
  logic          valid0;
  logic          valid1;
  logic [CW-1:0] fq_count;

  modport master (
    input  Icache_data_out,
    input  Icache_valid_out,
    input  redirect_en,
    input  redirect_pc,
    input  deq_count,
    output proc2Icache_addr,
    output stall_icache,
    output inst0,
    output inst1,
    output pc0,
    output pc1,
    output valid0,
    output valid1,
    output fq_count
  );

  modport slave (
    output Icache_data_out,
    output Icache_valid_out,
    output redirect_en,
    output redirect_pc,
    output deq_count,
    input  proc2Icache_addr,
    input  stall_icache,
    input  inst0,
    input  inst1,
    input  pc0,
    input  pc1,
    input  valid0,
    input  valid1,
    input  fq_count
  );

endinterface

// File: rtl/fq_ram.sv
// Fetch queue storage: two write ports, two async read ports.
// The two write addresses are never equal in the same cycle.
module fq_ram
  import sys_defs::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  fq_entry_t     wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  fq_entry_t     wd1,
  input  logic [AW-1:0] ra0,
  output fq_entry_t     rd0,
  input  logic [AW-1:0] ra1,
  output fq_entry_t     rd1
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch queue between icache and decode.
// Splits aligned 8-byte blocks into up to two {pc, inst} entries.
module fetch_buffer
  import sys_defs::*;
#(
  parameter int FQ_DEPTH = sys_defs::FQ_DEPTH
) (
  input logic           clock,
  input logic           reset,
  fetch_buffer_if.master fb
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   fetch_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [CW-1:0] space;
  logic [1:0]    need;
  logic          stall;
  logic          enq;
  logic          odd;
  logic [1:0]    enq_n;
  logic [1:0]    deq_req;
  logic [1:0]    deq_n;

  fq_entry_t wd0;
  fq_entry_t wd1;
  fq_entry_t rd0;
  fq_entry_t rd1;

  logic unused_rpc;
  assign unused_rpc = ^fb.redirect_pc[1:0];

  assign odd   = fetch_pc[2];
  assign need  = odd ? 2'd1 : 2'd2;
  assign space = CW'(FQ_DEPTH) - count;
  assign stall = space < CW'(need);
  assign enq   = fb.Icache_valid_out & ~stall & ~fb.redirect_en;
  assign enq_n = enq ? need : 2'd0;

  assign deq_req = (fb.deq_count == 2'd3) ? 2'd2 : fb.deq_count;
  assign deq_n   = (CW'(deq_req) > count) ? count[1:0] : deq_req;

  // An odd PC only supplies the high word of its block.
  always_comb begin
    wd0.pc   = fetch_pc;
    wd0.inst = odd ? fb.Icache_data_out[63:32]
                   : fb.Icache_data_out[31:0];
    wd1.pc   = fetch_pc + 64'd4;
    wd1.inst = fb.Icache_data_out[63:32];
  end

  fq_ram #(
    .DEPTH (FQ_DEPTH)
  ) u_ram (
    .clock (clock),
    .we0   (enq),
    .wa0   (tail),
    .wd0   (wd0),
    .we1   (enq & ~odd),
    .wa1   (tail + PW'(1)),
    .wd1   (wd1),
    .ra0   (head),
    .rd0   (rd0),
    .ra1   (head + PW'(1)),
    .rd1   (rd1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (fb.redirect_en) begin
      fetch_pc <= {fb.redirect_pc[63:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (enq) fetch_pc <= next_block(fetch_pc);
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  assign fb.proc2Icache_addr = fetch_pc;
  assign fb.stall_icache     = stall;
  assign fb.fq_count         = count;
  assign fb.valid0           = count >= CW'(1);
  assign fb.valid1           = count >= CW'(2);
  assign fb.inst0            = rd0.inst;
  assign fb.pc0              = rd0.pc;
  assign fb.inst1            = rd1.inst;
  assign fb.pc1              = rd1.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: vector table,
// directed corner sequences and random traffic vs a queue model.
module tb_fetch_buffer;

  localparam int D = 8;

  logic clock = 0;
  logic reset = 1;
  always #5 clock = ~clock;

  fetch_buffer_if #(.FQ_DEPTH(D)) fb ();

  fetch_buffer #(.FQ_DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .fb    (fb)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mpc;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic        r;
    logic        v;
    logic [63:0] d;
    logic        rd;
    logic [63:0] rp;
    logic [1:0]  dq;
    int          e_cnt;
    logic        e_v0;
    logic [31:0] e_inst0;
    logic [63:0] e_pc0;
    logic        e_stall;
    logic [63:0] e_addr;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic model_stall();
    int need;
    need = mpc[2] ? 1 : 2;
    return (D - mq.size()) < need;
  endfunction

  task automatic model_update(input logic r, v, input logic [63:0] d,
                              input logic rd, input logic [63:0] rp,
                              input logic [1:0] dq);
    int   dn;
    logic st;
    ent_t e;
    if (r) begin
      mq.delete();
      mpc = 0;
    end else if (rd) begin
      mq.delete();
      mpc = {rp[63:2], 2'b00};
    end else begin
      st = model_stall();
      dn = (dq == 3) ? 2 : int'(dq);
      if (dn > mq.size()) dn = mq.size();
      repeat (dn) void'(mq.pop_front());
      if (v && !st) begin
        if (!mpc[2]) begin
          e.pc = mpc;       e.inst = d[31:0];  mq.push_back(e);
          e.pc = mpc + 4;   e.inst = d[63:32]; mq.push_back(e);
        end else begin
          e.pc = mpc;       e.inst = d[63:32]; mq.push_back(e);
        end
        mpc = (mpc & ~64'd7) + 64'd8;
      end
    end
  endtask

  task automatic drive(input logic r, v, input logic [63:0] d,
                       input logic rd, input logic [63:0] rp,
                       input logic [1:0] dq);
    reset               = r;
    fb.Icache_valid_out = v;
    fb.Icache_data_out  = d;
    fb.redirect_en      = rd;
    fb.redirect_pc      = rp;
    fb.deq_count        = dq;
  endtask

  task automatic step(input logic r, v, input logic [63:0] d,
                      input logic rd, input logic [63:0] rp,
                      input logic [1:0] dq);
    drive(r, v, d, rd, rp, dq);
    @(posedge clock);
    model_update(r, v, d, rd, rp, dq);
    @(negedge clock);
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".count"}, 64'(fb.fq_count), 64'(mq.size()));
    chk({tag, ".valid0"}, 64'(fb.valid0), 64'(mq.size() >= 1));
    chk({tag, ".valid1"}, 64'(fb.valid1), 64'(mq.size() >= 2));
    chk({tag, ".stall"}, 64'(fb.stall_icache), 64'(model_stall()));
    chk({tag, ".addr"}, fb.proc2Icache_addr, mpc);
    if (mq.size() >= 1) begin
      chk({tag, ".inst0"}, 64'(fb.inst0), 64'(mq[0].inst));
      chk({tag, ".pc0"}, fb.pc0, mq[0].pc);
    end
    if (mq.size() >= 2) begin
      chk({tag, ".inst1"}, 64'(fb.inst1), 64'(mq[1].inst));
      chk({tag, ".pc1"}, fb.pc1, mq[1].pc);
    end
  endtask

  function automatic logic [63:0] blk(input logic [63:0] pc);
    return {pc[31:0] + 32'd4, pc[31:0]};
  endfunction

  initial begin
    logic [63:0] prev;
    logic [63:0] pc;

    vt[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 1, blk(0), 0, 0, 0, 2, 1, 0, 0, 0, 64'h8};
    vt[2] = '{0, 1, blk(8), 0, 0, 0, 4, 1, 0, 0, 0, 64'h10};
    vt[3] = '{0, 1, blk(16), 0, 0, 0, 6, 1, 0, 0, 0, 64'h18};
    vt[4] = '{0, 1, blk(24), 0, 0, 0, 8, 1, 0, 0, 1, 64'h20};
    vt[5] = '{0, 1, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 0,
              8, 1, 0, 0, 1, 64'h20};
    vt[6] = '{0, 1, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 2,
              6, 1, 32'h8, 64'h8, 0, 64'h20};
    vt[7] = '{0, 1, 64'h1234_5678_9ABC_DEF0, 1, 64'h106, 2,
              0, 0, 0, 0, 0, 64'h104};
    vt[8] = '{0, 1, 64'hAAAA_AAAA_BBBB_BBBB, 0, 0, 0,
              1, 1, 32'hAAAA_AAAA, 64'h104, 0, 64'h108};
    vt[9] = '{0, 1, 64'h0000_010C_0000_0108, 0, 0, 3,
              2, 1, 32'h108, 64'h108, 0, 64'h110};

    drive(1, 0, 0, 0, 0, 0);
    @(negedge clock);

    foreach (vt[i]) begin
      string tg;
      tg = $sformatf("vec%0d", i);
      step(vt[i].r, vt[i].v, vt[i].d, vt[i].rd, vt[i].rp, vt[i].dq);
      chk({tg, ".count"}, 64'(fb.fq_count), 64'(vt[i].e_cnt));
      chk({tg, ".valid0"}, 64'(fb.valid0), 64'(vt[i].e_v0));
      chk({tg, ".stall"}, 64'(fb.stall_icache), 64'(vt[i].e_stall));
      chk({tg, ".addr"}, fb.proc2Icache_addr, vt[i].e_addr);
      if (vt[i].e_v0) begin
        chk({tg, ".inst0"}, 64'(fb.inst0), 64'(vt[i].e_inst0));
        chk({tg, ".pc0"}, fb.pc0, vt[i].e_pc0);
      end
    end

    // count=7 on an even PC must stall regardless of dequeue
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 64'h4, 0);
    step(0, 1, blk(0), 0, 0, 0);
    step(0, 1, blk(8), 0, 0, 0);
    step(0, 1, blk(16), 0, 0, 0);
    step(0, 1, blk(24), 0, 0, 0);
    chk("sim.count7", 64'(fb.fq_count), 64'd7);
    drive(0, 1, blk(32), 0, 0, 2);
    #1;
    chk("sim.stall", 64'(fb.stall_icache), 64'd1);
    step(0, 1, blk(32), 0, 0, 2);
    chk("sim.count5", 64'(fb.fq_count), 64'd5);
    chk("sim.stall_clr", 64'(fb.stall_icache), 64'd0);
    model_check("sim");

    // redirect beats enqueue and dequeue
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, blk(0), 0, 0, 0);
    step(0, 1, blk(8), 0, 0, 0);
    step(0, 1, blk(16), 0, 0, 0);
    chk("rdp.count6", 64'(fb.fq_count), 64'd6);
    step(0, 1, blk(24), 1, 64'h2000, 2);
    chk("rdp.count", 64'(fb.fq_count), 64'd0);
    chk("rdp.valid0", 64'(fb.valid0), 64'd0);
    chk("rdp.addr", fb.proc2Icache_addr, 64'h2000);

    // steady enqueue/dequeue wraps head and tail several times
    step(1, 0, 0, 0, 0, 0);
    pc = 0;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, blk(pc), 0, 0, 2);
      pc += 8;
      if (i > 0) chk($sformatf("wrap%0d.pc0", i), fb.pc0, prev + 8);
      chk($sformatf("wrap%0d.pc1", i), fb.pc1, fb.pc0 + 4);
      prev = fb.pc0;
      model_check($sformatf("wrap%0d", i));
    end

    // reset mid-stream drops everything
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, blk(0), 0, 0, 0);
    step(0, 1, blk(8), 0, 0, 0);
    step(0, 1, blk(16), 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rst.count5", 64'(fb.fq_count), 64'd5);
    step(1, 1, blk(24), 0, 0, 1);
    chk("rst.count", 64'(fb.fq_count), 64'd0);
    chk("rst.valid0", 64'(fb.valid0), 64'd0);
    chk("rst.valid1", 64'(fb.valid1), 64'd0);
    chk("rst.stall", 64'(fb.stall_icache), 64'd0);
    chk("rst.addr", fb.proc2Icache_addr, 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic        r, v, rd;
      logic [63:0] d, rp;
      logic [1:0]  dq;
      r  = ($urandom_range(99) < 2);
      rd = ($urandom_range(99) < 5);
      v  = ($urandom_range(99) < 75);
      d  = {$urandom, $urandom};
      rp = {$urandom, $urandom};
      dq = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF4;
      step(r, v, d, rd, rp, dq);
      model_check($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
